// File: rtl/alu_secuencial.sv
// Handshaked sequential ALU: single-cycle arith/logic ops, iterative 1-bit-per-cycle shifts.
// Define ALU_MULT_EN to compile in the iterative signed shift-add multiplier (opcode 011000).
module alu_secuencial #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dato_A,
    input  logic [DATA_WIDTH-1:0] dato_B,
    input  logic [OP_WIDTH-1:0]   op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] resultado,
    output logic                  flag_zero,
    output logic                  flag_carry,
    output logic                  flag_ovf,
    output logic                  op_invalido
);
    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam int MSB  = DATA_WIDTH - 1;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(6'b100000);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(6'b100010);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(6'b100100);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(6'b100101);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(6'b100110);
    localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'(6'b100111);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(6'b101010);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(6'b000010);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(6'b000011);
`ifdef ALU_MULT_EN
    localparam logic [OP_WIDTH-1:0] OP_MULT = OP_WIDTH'(6'b011000);
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA, K_MUL} kind_t;

    state_t                state, state_next;
    kind_t                 kind_q, kind_d;
    logic [DATA_WIDTH-1:0] acc;
    logic [SH_W-1:0]       cnt;
    logic                  accept;
    logic                  is_iter;
    logic [DATA_WIDTH:0]   sum, diff;
    logic [DATA_WIDTH-1:0] sc_res;
    logic                  sc_carry, sc_ovf, sc_inv;
    logic [DATA_WIDTH-1:0] shifted, it_res;
    logic                  it_done, it_ovf;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // One extra bit holds the ADD carry-out / SUB unsigned borrow.
    assign sum  = {1'b0, dato_A} + {1'b0, dato_B};
    assign diff = {1'b0, dato_A} - {1'b0, dato_B};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_inv   = 1'b0;
        is_iter  = 1'b0;
        kind_d   = K_SLL;
        case (op)
            OP_ADD: begin
                sc_res   = sum[MSB:0];
                sc_carry = sum[DATA_WIDTH];
                sc_ovf   = (dato_A[MSB] == dato_B[MSB]) && (sum[MSB] != dato_A[MSB]);
            end
            OP_SUB: begin
                sc_res   = diff[MSB:0];
                sc_carry = diff[DATA_WIDTH];
                sc_ovf   = (dato_A[MSB] != dato_B[MSB]) && (diff[MSB] != dato_A[MSB]);
            end
            OP_AND: sc_res = dato_A & dato_B;
            OP_OR:  sc_res = dato_A | dato_B;
            OP_XOR: sc_res = dato_A ^ dato_B;
            OP_NOR: sc_res = ~(dato_A | dato_B);
            OP_SLT: sc_res[0] = $signed(dato_A) < $signed(dato_B);
            OP_SLL: begin is_iter = 1'b1; kind_d = K_SLL; end
            OP_SRL: begin is_iter = 1'b1; kind_d = K_SRL; end
            OP_SRA: begin is_iter = 1'b1; kind_d = K_SRA; end
`ifdef ALU_MULT_EN
            OP_MULT: begin is_iter = 1'b1; kind_d = K_MUL; end
`endif
            default: sc_inv = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = is_iter ? BUSY : DONE;
            BUSY: if (it_done) state_next = DONE;
            DONE: begin
                if (accept)         state_next = is_iter ? BUSY : DONE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ALU_MULT_EN
    logic [2*DATA_WIDTH-1:0] prod, mcand, prod_next;
    logic [DATA_WIDTH-1:0]   mplier;

    // The multiplier MSB carries negative weight in two's complement, so its partial product is subtracted.
    always_comb begin
        prod_next = prod;
        if (mplier[0])
            prod_next = (cnt == SH_W'(DATA_WIDTH - 1)) ? prod - mcand : prod + mcand;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept) begin
            prod   <= '0;
            mcand  <= {{DATA_WIDTH{dato_A[MSB]}}, dato_A};
            mplier <= dato_B;
        end else if (state == BUSY && kind_q == K_MUL) begin
            prod   <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`endif

    always_comb begin
        shifted = acc;
        case (kind_q)
            K_SLL:   shifted = {acc[MSB-1:0], 1'b0};
            K_SRL:   shifted = {1'b0, acc[MSB:1]};
            K_SRA:   shifted = {acc[MSB], acc[MSB:1]};
            default: shifted = acc;
        endcase
        // A zero shift amount spends one BUSY cycle and returns A untouched.
        it_done = (cnt <= SH_W'(1));
        it_res  = (cnt == '0) ? acc : shifted;
        it_ovf  = 1'b0;
`ifdef ALU_MULT_EN
        if (kind_q == K_MUL) begin
            it_done = (cnt == SH_W'(DATA_WIDTH - 1));
            it_res  = prod_next[MSB:0];
            it_ovf  = prod_next[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{prod_next[MSB]}};
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the result register is reset too, since it is visible at the outputs straight after reset.
            acc         <= '0;
            cnt         <= '0;
            kind_q      <= K_SLL;
            resultado   <= '0;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
            flag_ovf    <= 1'b0;
            op_invalido <= 1'b0;
        end else if (accept) begin
            acc    <= dato_A;
            kind_q <= kind_d;
            cnt    <= (kind_d == K_MUL) ? '0 : dato_B[SH_W-1:0];
            if (!is_iter) begin
                resultado   <= sc_res;
                flag_zero   <= (sc_res == '0);
                flag_carry  <= sc_carry;
                flag_ovf    <= sc_ovf;
                op_invalido <= sc_inv;
            end
        end else if (state == BUSY) begin
            acc <= shifted;
            cnt <= (kind_q == K_MUL) ? cnt + SH_W'(1) : cnt - SH_W'(1);
            if (it_done) begin
                resultado   <= it_res;
                flag_zero   <= (it_res == '0);
                flag_carry  <= 1'b0;
                flag_ovf    <= it_ovf;
                op_invalido <= 1'b0;
            end
        end
    end

endmodule
